// File: rtl/time_counter_cfg.sv
// Configurable BCD time-of-day counter with prescaler, digit load and 12/24 h display.
// Time is held internally as 24 h BCD digits; the display mapping is combinational.
module time_counter_cfg #(
    parameter int TICK_DIV = 60,
    parameter bit SEC_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] ld_u_sec,
    input  logic [2:0] ld_z_sec,
    input  logic [3:0] ld_u_min,
    input  logic [2:0] ld_z_min,
    input  logic [3:0] ld_u_hour,
    input  logic [1:0] ld_z_hour,
    input  logic       mode12,
    output logic [3:0] u_sec,
    output logic [2:0] z_sec,
    output logic [3:0] u_min,
    output logic [2:0] z_min,
    output logic [3:0] u_hour,
    output logic [1:0] z_hour,
    output logic       pm,
    output logic       min_pulse,
    output logic       day_wrap,
    output logic       load_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [3:0]    us_q, us_d;
    logic [2:0]    zs_q, zs_d;
    logic [3:0]    um_q, um_d;
    logic [2:0]    zm_q, zm_d;
    logic [3:0]    uh_q, uh_d;
    logic [1:0]    zh_q, zh_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          mp_q, mp_d;
    logic          dw_q, dw_d;
    logic          err_q, err_d;

    logic tick, sec_wrap, min_wrap, hr_wrap, ld_ok;

    always_comb begin
        tick     = en && (pre_q == PMAX);
        sec_wrap = SEC_EN ? (us_q == 4'd9 && zs_q == 3'd5) : 1'b1;
        min_wrap = (um_q == 4'd9) && (zm_q == 3'd5);
        hr_wrap  = (zh_q == 2'd2) && (uh_q == 4'd3);
        ld_ok    = (ld_u_min <= 4'd9) && (ld_z_min <= 3'd5)
                && (ld_u_hour <= 4'd9) && (ld_z_hour <= 2'd2)
                && !(ld_z_hour == 2'd2 && ld_u_hour > 4'd3)
                && (!SEC_EN || (ld_u_sec <= 4'd9 && ld_z_sec <= 3'd5));

        us_d  = us_q;
        zs_d  = zs_q;
        um_d  = um_q;
        zm_d  = zm_q;
        uh_d  = uh_q;
        zh_d  = zh_q;
        pre_d = pre_q;
        mp_d  = 1'b0;
        dw_d  = 1'b0;
        err_d = err_q;

        // A load (valid or not) swallows any tick due in the same cycle.
        if (load) begin
            if (ld_ok) begin
                us_d  = SEC_EN ? ld_u_sec : 4'd0;
                zs_d  = SEC_EN ? ld_z_sec : 3'd0;
                um_d  = ld_u_min;
                zm_d  = ld_z_min;
                uh_d  = ld_u_hour;
                zh_d  = ld_z_hour;
                pre_d = '0;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (SEC_EN) begin
                    us_d = (us_q == 4'd9) ? 4'd0 : us_q + 4'd1;
                    if (us_q == 4'd9)
                        zs_d = (zs_q == 3'd5) ? 3'd0 : zs_q + 3'd1;
                end
                if (sec_wrap) begin
                    mp_d = 1'b1;
                    um_d = (um_q == 4'd9) ? 4'd0 : um_q + 4'd1;
                    if (um_q == 4'd9)
                        zm_d = (zm_q == 3'd5) ? 3'd0 : zm_q + 3'd1;
                    if (min_wrap) begin
                        dw_d = hr_wrap;
                        if (hr_wrap) begin
                            uh_d = 4'd0;
                            zh_d = 2'd0;
                        end else if (uh_q == 4'd9) begin
                            uh_d = 4'd0;
                            zh_d = zh_q + 2'd1;
                        end else begin
                            uh_d = uh_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_q  <= '0;
            zs_q  <= '0;
            um_q  <= '0;
            zm_q  <= '0;
            uh_q  <= '0;
            zh_q  <= '0;
            pre_q <= '0;
            mp_q  <= 1'b0;
            dw_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            us_q  <= us_d;
            zs_q  <= zs_d;
            um_q  <= um_d;
            zm_q  <= zm_d;
            uh_q  <= uh_d;
            zh_q  <= zh_d;
            pre_q <= pre_d;
            mp_q  <= mp_d;
            dw_q  <= dw_d;
            err_q <= err_d;
        end
    end

    logic [4:0] hbin, hdisp;
    logic [1:0] zh_o;

    always_comb begin
        hbin = 5'(zh_q) * 5'd10 + 5'(uh_q);
        hdisp = hbin;
        if (mode12) begin
            if (hbin == 5'd0)
                hdisp = 5'd12;
            else if (hbin > 5'd12)
                hdisp = hbin - 5'd12;
        end
        if (hdisp >= 5'd20)
            zh_o = 2'd2;
        else if (hdisp >= 5'd10)
            zh_o = 2'd1;
        else
            zh_o = 2'd0;
    end

    assign u_sec     = us_q;
    assign z_sec     = zs_q;
    assign u_min     = um_q;
    assign z_min     = zm_q;
    assign z_hour    = zh_o;
    assign u_hour    = 4'(hdisp - 5'(zh_o) * 5'd10);
    assign pm        = hbin >= 5'd12;
    assign min_pulse = mp_q;
    assign day_wrap  = dw_q;
    assign load_err  = err_q;

endmodule
